tft_pixel_writer: RTL and testbench
===================================

# tft_pixel_writer

Read side of the UART-to-TFT pixel path. The sync FIFO is filled with 16-bit RGB565 pixels by the UART front end. This block pops those pixels and drives them onto an 8080-style parallel TFT write bus. Each frame is one memory-write command followed by exactly H_PIXELS×V_PIXELS pixel writes with programmable WR strobe timing. It stalls cleanly on FIFO underflow.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel/bus width
- H_PIXELS, 256, pixels per line
- V_PIXELS, 256, lines per frame
- WR_LOW, 2, cycles lcd_wr_n held low per write (1..255)
- WR_HIGH, 2, cycles lcd_wr_n held high per write (1..255)
- RAMWR_CMD, 16'h002C, command word issued at frame start

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request
- fifo_data  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop
- lcd_cs_n  out  1  chip select, active-low
- lcd_rs  out  1  0 = command, 1 = pixel data
- lcd_wr_n  out  1  write strobe; panel latches on rising edge
- lcd_rd_n  out  1  tied 1 (no reads)
- lcd_data  out  DATA_WIDTH  bus data
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel's strobe completes

## Operation
- States: IDLE, CMD_LO, CMD_HI, POP, FETCH, PIX_LO, PIX_HI, DONE.
- IDLE → CMD_LO on start:
  - lcd_data=RAMWR_CMD, lcd_rs=0, lcd_cs_n=0, busy=1.
  - x and y counters cleared.
- CMD_LO: lcd_wr_n=0 for WR_LOW cycles → CMD_HI.
- CMD_HI: lcd_wr_n=1 for WR_HIGH cycles → POP.
- POP:
  - fifo_rd_en = (state==POP) && !fifo_empty. This is a combinational decode of registered signals.
  - If !fifo_empty → FETCH; otherwise remain in POP.
- FETCH:
  - lcd_data ← fifo_data, lcd_rs ← 1.
  - → PIX_LO.
- PIX_LO: lcd_wr_n=0 for WR_LOW cycles → PIX_HI.
- PIX_HI: lcd_wr_n=1 for WR_HIGH cycles. In the final PIX_HI cycle:
  - If x==H_PIXELS-1 and y==V_PIXELS-1 → DONE.
  - Else advance x (wrap to 0 and increment y at H_PIXELS-1) → POP.
- DONE:
  - frame_done=1 for one cycle, lcd_cs_n ← 1, busy ← 0.
  - → IDLE.
- Counters:
  - x width clog2(H_PIXELS); y width clog2(V_PIXELS); phase counter 8 bits.
  - Exactly one pop per pixel; never more than H_PIXELS×V_PIXELS pops per frame.
- lcd_data and lcd_rs are stable for the whole LO+HI window of every write.

## Timing
- Reset values: state IDLE, fifo_rd_en=0, lcd_cs_n=1, lcd_rs=1, lcd_wr_n=1, lcd_rd_n=1, lcd_data=0, busy=0, frame_done=0, counters 0.
- Start latency: start high at edge k → lcd_cs_n=0, lcd_rs=0, lcd_data=RAMWR_CMD, lcd_wr_n=0 from edge k+1.
- Pixel cadence with FIFO non-empty: 2+WR_LOW+WR_HIGH cycles per pixel (6 at defaults).
- Underflow stall in POP:
  - lcd_wr_n=1, lcd_cs_n=0, lcd_data holds the last pixel, fifo_rd_en=0.
  - Pop occurs in the first cycle fifo_empty is low.
- start is ignored when not in IDLE, including during DONE. The block does not queue start.
- Reset mid-frame (any state): outputs take reset values at the next edge. The frame is abandoned and a later start begins with a new command. FIFO contents are not touched.
- lcd_rd_n is constant 1 at all times.

## Test plan
- Reset: assert reset 3 cycles in the middle of random stimulus → all outputs at the listed reset values one edge later; no fifo_rd_en pulse.
- Small frame (H_PIXELS=4, V_PIXELS=2), FIFO preloaded 0x0001..0x0008, start pulse:
  - Required: one write with lcd_rs=0 and data 0x002C, then 8 writes with lcd_rs=1 carrying 0x0001..0x0008 in order.
  - Exactly 8 fifo_rd_en pulses, 6 cycles per pixel, one frame_done pulse, busy low afterwards.
- Underflow: FIFO holds 3 words; refill with 5 more 20 cycles later → 3 writes, then lcd_wr_n=1 and lcd_cs_n=0 with no fifo_rd_en for the stall, then pixels 4..8 resume with no lost or duplicated data.
- start held high throughout a frame and pulsed during DONE → only one frame runs. A fresh start in IDLE begins a second frame starting with command 0x002C.
- Reset during the third pixel's PIX_LO → lcd_wr_n=1 and lcd_cs_n=1 on the next edge. A following start issues the command, then pixels continue from the FIFO head.
- WR_LOW=1, WR_HIGH=3 → every strobe is low for 1 cycle and high for 3; per-pixel period is 6 cycles; data is stable across each window.

Source files
------------

// File: rtl/tft_pixel_writer.sv
// tft_pixel_writer: pops RGB565 pixels from a sync FIFO and writes one frame
// (RAMWR command + H_PIXELS*V_PIXELS pixels) onto an 8080-style TFT bus.
module tft_pixel_writer #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           H_PIXELS   = 256,
    parameter int unsigned           V_PIXELS   = 256,
    parameter int unsigned           WR_LOW     = 2,
    parameter int unsigned           WR_HIGH    = 2,
    parameter logic [DATA_WIDTH-1:0] RAMWR_CMD  = 16'h002C
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  lcd_cs_n,
    output logic                  lcd_rs,
    output logic                  lcd_wr_n,
    output logic                  lcd_rd_n,
    output logic [DATA_WIDTH-1:0] lcd_data,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int unsigned PW = 8;

    localparam logic [XW-1:0] X_LAST  = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_PIXELS - 1);
    localparam logic [PW-1:0] LO_LAST = PW'(WR_LOW - 1);
    localparam logic [PW-1:0] HI_LAST = PW'(WR_HIGH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD_LO,
        CMD_HI,
        POP,
        FETCH,
        PIX_LO,
        PIX_HI,
        DONE
    } state_t;

    state_t                r_state;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [PW-1:0]         r_phase;
    logic                  r_cs_n;
    logic                  r_rs;
    logic                  r_wr_n;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;

    // Pop only while waiting for a pixel and the FIFO has one; decoded from registered state.
    assign fifo_rd_en = (r_state == POP) && !fifo_empty;

    assign lcd_cs_n   = r_cs_n;
    assign lcd_rs     = r_rs;
    assign lcd_wr_n   = r_wr_n;
    assign lcd_rd_n   = 1'b1;
    assign lcd_data   = r_data;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Frame sequencer: command write, then per pixel pop/fetch/strobe-low/strobe-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= '0;
            r_cs_n  <= 1'b1;
            r_rs    <= 1'b1;
            r_wr_n  <= 1'b1;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CMD_LO;
                        r_data  <= RAMWR_CMD;
                        r_rs    <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_phase <= '0;
                    end
                end
                CMD_LO: begin
                    if (r_phase == LO_LAST) begin
                        r_phase <= '0;
                        r_wr_n  <= 1'b1;
                        r_state <= CMD_HI;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                CMD_HI: begin
                    if (r_phase == HI_LAST) begin
                        r_phase <= '0;
                        r_state <= POP;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                POP: begin
                    if (!fifo_empty) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // Popped word is valid now; bus data and strobe change together.
                    r_data  <= fifo_data;
                    r_rs    <= 1'b1;
                    r_wr_n  <= 1'b0;
                    r_phase <= '0;
                    r_state <= PIX_LO;
                end
                PIX_LO: begin
                    if (r_phase == LO_LAST) begin
                        r_phase <= '0;
                        r_wr_n  <= 1'b1;
                        r_state <= PIX_HI;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                PIX_HI: begin
                    if (r_phase == HI_LAST) begin
                        r_phase <= '0;
                        if ((r_x == X_LAST) && (r_y == Y_LAST)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_cs_n  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                r_y <= r_y + YW'(1);
                            end else begin
                                r_x <= r_x + XW'(1);
                            end
                            r_state <= POP;
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tft_pixel_writer.sv
// tb_tft_pixel_writer: directed scoreboard bench for tft_pixel_writer (4x2 frame,
// default 2/2 strobe timing on dut0, 1/3 strobe timing on dut1).
module tb_tft_pixel_writer;

    localparam int unsigned DW = 16;
    localparam int unsigned HP = 4;
    localparam int unsigned VP = 2;
    localparam int          L0 = 2;
    localparam int          H0 = 2;
    localparam int          L1 = 1;
    localparam int          H1 = 3;
    localparam logic [15:0] CMD = 16'h002C;

    logic clk = 1'b0;
    logic reset;
    logic start0, start1;

    logic          fifo_empty0, fifo_rd_en0, lcd_cs_n0, lcd_rs0, lcd_wr_n0, lcd_rd_n0, busy0, frame_done0;
    logic [DW-1:0] fifo_data0 = '0;
    logic [DW-1:0] lcd_data0;
    logic          fifo_empty1, fifo_rd_en1, lcd_cs_n1, lcd_rs1, lcd_wr_n1, lcd_rd_n1, busy1, frame_done1;
    logic [DW-1:0] fifo_data1 = '0;
    logic [DW-1:0] lcd_data1;

    tft_pixel_writer #(.DATA_WIDTH(DW), .H_PIXELS(HP), .V_PIXELS(VP),
                       .WR_LOW(L0), .WR_HIGH(H0), .RAMWR_CMD(CMD)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .fifo_empty(fifo_empty0),
        .fifo_rd_en(fifo_rd_en0), .fifo_data(fifo_data0), .lcd_cs_n(lcd_cs_n0),
        .lcd_rs(lcd_rs0), .lcd_wr_n(lcd_wr_n0), .lcd_rd_n(lcd_rd_n0),
        .lcd_data(lcd_data0), .busy(busy0), .frame_done(frame_done0));

    tft_pixel_writer #(.DATA_WIDTH(DW), .H_PIXELS(HP), .V_PIXELS(VP),
                       .WR_LOW(L1), .WR_HIGH(H1), .RAMWR_CMD(CMD)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .fifo_empty(fifo_empty1),
        .fifo_rd_en(fifo_rd_en1), .fifo_data(fifo_data1), .lcd_cs_n(lcd_cs_n1),
        .lcd_rs(lcd_rs1), .lcd_wr_n(lcd_wr_n1), .lcd_rd_n(lcd_rd_n1),
        .lcd_data(lcd_data1), .busy(busy1), .frame_done(frame_done1));

    always #5 clk = ~clk;

    // FIFO models: read data valid the cycle after an accepted pop.
    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];
    logic [5:0]  wptr0, wptr1;
    logic [5:0]  rptr0 = '0;
    logic [5:0]  rptr1 = '0;
    int          pops0 = 0, pops1 = 0, ufl0 = 0, ufl1 = 0;

    assign fifo_empty0 = (wptr0 == rptr0);
    assign fifo_empty1 = (wptr1 == rptr1);

    always @(posedge clk) begin
        if (fifo_rd_en0) begin
            pops0 <= pops0 + 1;
            if (fifo_empty0) ufl0 <= ufl0 + 1;
            else begin
                fifo_data0 <= mem0[rptr0];
                rptr0      <= rptr0 + 6'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (fifo_rd_en1) begin
            pops1 <= pops1 + 1;
            if (fifo_empty1) ufl1 <= ufl1 + 1;
            else begin
                fifo_data1 <= mem1[rptr1];
                rptr1      <= rptr1 + 6'd1;
            end
        end
    end

    int          total = 0, passed = 0, cyc = 0;
    logic [16:0] exp0[$];
    logic [16:0] exp1[$];
    bit          prev_wr[2], have_fall[2], per_chk[2], mon_en[2];
    int          lo_cnt[2], fall_cnt[2], wr_cnt[2], done_cnt[2], last_fall[2];
    logic [16:0] lat[2];

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic put0(input logic [15:0] d, input bit with_exp);
        mem0[wptr0] = d;
        wptr0 = wptr0 + 6'd1;
        if (with_exp) exp0.push_back({1'b1, d});
    endtask

    task automatic put1(input logic [15:0] d, input bit with_exp);
        mem1[wptr1] = d;
        wptr1 = wptr1 + 6'd1;
        if (with_exp) exp1.push_back({1'b1, d});
    endtask

    // Bus monitor: strobe widths, period, bus stability, and scoreboard pop on wr_n rise.
    task automatic mon_step(input int id, input logic wr_n, input logic cs_n,
                            input logic [16:0] cur, input int lo_w, input int hi_w);
        bit          have_e;
        logic [16:0] e;
        if (reset) begin
            prev_wr[id]   = 1'b1;
            have_fall[id] = 1'b0;
            return;
        end
        if (!mon_en[id]) return;
        if (cs_n) have_fall[id] = 1'b0;
        if (prev_wr[id] && !wr_n) begin
            fall_cnt[id]++;
            lat[id]    = cur;
            lo_cnt[id] = 1;
            if (per_chk[id] && have_fall[id])
                check("pixel_period", cyc - last_fall[id], lo_w + hi_w + 2);
            last_fall[id] = cyc;
            have_fall[id] = 1'b1;
        end else begin
            if (!wr_n) lo_cnt[id]++;
            if (!cs_n) check("bus_stable", int'(cur), int'(lat[id]));
        end
        if (!prev_wr[id] && wr_n && !cs_n) begin
            check("low_width", lo_cnt[id], lo_w);
            have_e = (id == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
            check("write_expected", int'(have_e), 1);
            if (have_e) begin
                if (id == 0) e = exp0.pop_front();
                else         e = exp1.pop_front();
                check("write_word", int'(cur), int'(e));
            end
            wr_cnt[id]++;
        end
        prev_wr[id] = wr_n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mon_step(0, lcd_wr_n0, lcd_cs_n0, {lcd_rs0, lcd_data0}, L0, H0);
        mon_step(1, lcd_wr_n1, lcd_cs_n1, {lcd_rs1, lcd_data1}, L1, H1);
        if (frame_done0) done_cnt[0]++;
        if (frame_done1) done_cnt[1]++;
    endtask

    task automatic wait_done(input int id, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = (id == 0) ? frame_done0 : frame_done1;
        end
        check("frame_done_seen", int'(seen), 1);
    endtask

    task automatic check_rst(input string who, input logic rd_en, input logic cs_n,
                             input logic rs, input logic wr_n, input logic rd_n,
                             input logic bsy, input logic done, input logic [15:0] d);
        check({who, "_rst_rd_en"}, int'(rd_en), 0);
        check({who, "_rst_cs_n"},  int'(cs_n),  1);
        check({who, "_rst_rs"},    int'(rs),    1);
        check({who, "_rst_wr_n"},  int'(wr_n),  1);
        check({who, "_rst_rd_n"},  int'(rd_n),  1);
        check({who, "_rst_busy"},  int'(bsy),   0);
        check({who, "_rst_done"},  int'(done),  0);
        check({who, "_rst_data"},  int'(d),     0);
    endtask

    int p_snap, w_snap, d_snap, f_snap;
    bit reached;

    initial begin
        wptr0 = '0;
        wptr1 = '0;
        for (int i = 0; i < 2; i++) begin
            prev_wr[i] = 1'b1; have_fall[i] = 1'b0; per_chk[i] = 1'b0; mon_en[i] = 1'b0;
            lo_cnt[i] = 0; fall_cnt[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0; last_fall[i] = 0;
            lat[i] = '0;
        end
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset in the middle of random start activity; FIFO loaded while held in reset.
        for (int i = 0; i < 6; i++) begin
            start0 = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b1;
        p_snap = pops0;
        for (int i = 0; i < 3; i++) begin
            start0 = 1'($urandom_range(0, 1));
            tick();
            if (i == 0) for (int k = 1; k <= 8; k++) put0(16'(k), 1'b0);
            check_rst("dut0", fifo_rd_en0, lcd_cs_n0, lcd_rs0, lcd_wr_n0, lcd_rd_n0, busy0, frame_done0, lcd_data0);
        end
        check_rst("dut1", fifo_rd_en1, lcd_cs_n1, lcd_rs1, lcd_wr_n1, lcd_rd_n1, busy1, frame_done1, lcd_data1);
        check("rst_no_pop", pops0 - p_snap, 0);
        reset = 1'b0; start0 = 1'b0;
        mon_en[0] = 1'b1; mon_en[1] = 1'b1;

        // Small frame from preloaded FIFO 0x0001..0x0008.
        exp0.push_back({1'b0, CMD});
        for (int k = 1; k <= 8; k++) exp0.push_back({1'b1, 16'(k)});
        per_chk[0] = 1'b1;
        p_snap = pops0; w_snap = wr_cnt[0]; d_snap = done_cnt[0];
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_cs_n", int'(lcd_cs_n0), 0);
        check("start_rs",   int'(lcd_rs0),   0);
        check("start_data", int'(lcd_data0), int'(CMD));
        check("start_wr_n", int'(lcd_wr_n0), 0);
        check("start_busy", int'(busy0),     1);
        wait_done(0, 200);
        check("done_busy_low", int'(busy0), 0);
        check("done_cs_high", int'(lcd_cs_n0), 1);
        tick();
        check("done_one_cycle", int'(frame_done0), 0);
        tick(); tick();
        check("frame_pops", pops0 - p_snap, 8);
        check("frame_writes", wr_cnt[0] - w_snap, 9);
        check("frame_done_count", done_cnt[0] - d_snap, 1);
        check("frame_exp_drained", exp0.size(), 0);
        check("idle_busy", int'(busy0), 0);
        per_chk[0] = 1'b0;

        // Underflow: 3 words, stall in POP, then 5 more.
        exp0.push_back({1'b0, CMD});
        for (int k = 1; k <= 3; k++) put0(16'(16'h0010 + k), 1'b1);
        p_snap = pops0; w_snap = wr_cnt[0];
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            tick();
            reached = (wr_cnt[0] - w_snap) >= 4;
        end
        check("ufl_three_written", int'(reached), 1);
        for (int n = 0; n < 20; n++) begin
            tick();
            check("stall_wr_n", int'(lcd_wr_n0), 1);
            check("stall_cs_n", int'(lcd_cs_n0), 0);
            check("stall_rd_en", int'(fifo_rd_en0), 0);
            check("stall_data", int'(lcd_data0), 16'h0013);
        end
        check("stall_pops", pops0 - p_snap, 3);
        for (int k = 4; k <= 8; k++) put0(16'(16'h0010 + k), 1'b1);
        wait_done(0, 200);
        check("ufl_pops", pops0 - p_snap, 8);
        check("ufl_writes", wr_cnt[0] - w_snap, 9);
        check("ufl_exp_drained", exp0.size(), 0);
        check("ufl_no_empty_pop", ufl0, 0);

        // start held high all frame, including DONE: exactly one frame.
        exp0.push_back({1'b0, CMD});
        for (int k = 1; k <= 8; k++) put0(16'(16'h0020 + k), 1'b1);
        per_chk[0] = 1'b1;
        p_snap = pops0; w_snap = wr_cnt[0]; d_snap = done_cnt[0];
        start0 = 1'b1;
        wait_done(0, 200);
        tick();
        start0 = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        check("hold_busy", int'(busy0), 0);
        check("hold_cs_n", int'(lcd_cs_n0), 1);
        check("hold_done_count", done_cnt[0] - d_snap, 1);
        check("hold_writes", wr_cnt[0] - w_snap, 9);
        check("hold_pops", pops0 - p_snap, 8);
        per_chk[0] = 1'b0;

        // Reset during the third pixel's PIX_LO, then restart from FIFO head.
        exp0.push_back({1'b0, CMD});
        for (int k = 1; k <= 8; k++) put0(16'(16'h0030 + k), 1'b1);
        p_snap = pops0; f_snap = fall_cnt[0];
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            if ((fall_cnt[0] - f_snap) >= 4) reached = 1'b1;
            else tick();
        end
        check("px3_low_reached", int'(reached), 1);
        check("px3_wr_low", int'(lcd_wr_n0), 0);
        check("px3_pending", exp0.size(), 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_wr_n", int'(lcd_wr_n0), 1);
        check("midrst_cs_n", int'(lcd_cs_n0), 1);
        check("midrst_busy", int'(busy0), 0);
        check("midrst_pops", pops0 - p_snap, 3);
        exp0.delete();
        exp0.push_back({1'b0, CMD});
        for (int k = 4; k <= 8; k++) exp0.push_back({1'b1, 16'(16'h0030 + k)});
        for (int k = 9; k <= 11; k++) put0(16'(16'h0030 + k), 1'b1);
        p_snap = pops0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("restart_data", int'(lcd_data0), int'(CMD));
        check("restart_rs", int'(lcd_rs0), 0);
        wait_done(0, 200);
        check("restart_pops", pops0 - p_snap, 8);
        check("restart_exp_drained", exp0.size(), 0);

        // dut1: WR_LOW=1, WR_HIGH=3 timing.
        exp1.push_back({1'b0, CMD});
        for (int k = 1; k <= 8; k++) put1(16'(16'hA000 + k * 16'h0101), 1'b1);
        per_chk[1] = 1'b1;
        w_snap = wr_cnt[1];
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t13_start_wr_n", int'(lcd_wr_n1), 0);
        tick();
        check("t13_wr_high_after_1", int'(lcd_wr_n1), 1);
        wait_done(1, 200);
        tick();
        check("t13_pops", pops1, 8);
        check("t13_writes", wr_cnt[1] - w_snap, 9);
        check("t13_exp_drained", exp1.size(), 0);
        check("t13_done_count", done_cnt[1], 1);
        check("rd_n_const", int'(lcd_rd_n0 & lcd_rd_n1), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
